// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared types and constants for the gate sweep checker.
package gate_check_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam int NUM_VECTORS = 4;
   localparam int BIT_NOT = 2;
   localparam int BIT_AND = 1;
   localparam int BIT_OR  = 0;
   function automatic logic [3:0] popcount3(input logic [2:0] v);
      return {3'b0, v[0]} + {3'b0, v[1]} + {3'b0, v[2]};
   endfunction
endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if: gate stimulus/response and sweep result bundle.
interface gate_sweep_checker_if;
   logic       start;
   logic       A;
   logic       B;
   logic       out_NOT;
   logic       out_AND;
   logic       out_OR;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic [3:0] fail_vec;
   logic [4:0] first_fail;
   logic       first_fail_valid;
   modport master (
      input  start, out_NOT, out_AND, out_OR,
      output A, B, busy, done, pass, err_count, fail_vec, first_fail, first_fail_valid
   );
   modport slave (
      output start, out_NOT, out_AND, out_OR,
      input  A, B, busy, done, pass, err_count, fail_vec, first_fail, first_fail_valid
   );
endinterface

// File: rtl/gate_expect.sv
// gate_expect: golden combinational model of the NOT/AND/OR gate block.
module gate_expect
   import gate_check_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [2:0] expected
);
   always_comb begin
      expected = '0;
      expected[BIT_NOT] = ~a;
      expected[BIT_AND] = a & b;
      expected[BIT_OR]  = a | b;
   end
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps A/B over all four vectors and checks gate outputs.
module gate_sweep_checker
   import gate_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input logic clk,
   input logic rst_n,
   gate_sweep_checker_if.master bus
);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
   localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);
   state_t     state;
   logic [3:0] cnt;
   logic [1:0] idx;
   logic [2:0] expected;
   logic [2:0] actual;
   logic [2:0] mismatch;
   logic [3:0] err_next;
   gate_expect u_expect (.a(bus.A), .b(bus.B), .expected(expected));
   always_comb begin
      actual = '0;
      actual[BIT_NOT] = bus.out_NOT;
      actual[BIT_AND] = bus.out_AND;
      actual[BIT_OR]  = bus.out_OR;
      mismatch = actual ^ expected;
      err_next = bus.err_count + popcount3(mismatch);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                <= IDLE;
         cnt                  <= '0;
         idx                  <= '0;
         bus.A                <= 1'b0;
         bus.B                <= 1'b0;
         bus.busy             <= 1'b0;
         bus.done             <= 1'b0;
         bus.pass             <= 1'b0;
         bus.err_count        <= '0;
         bus.fail_vec         <= '0;
         bus.first_fail       <= '0;
         bus.first_fail_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (bus.start) begin
               state                <= SETTLE;
               cnt                  <= SETTLE_LOAD;
               idx                  <= '0;
               {bus.A, bus.B}       <= 2'b00;
               bus.busy             <= 1'b1;
               bus.done             <= 1'b0;
               bus.pass             <= 1'b0;
               bus.err_count        <= '0;
               bus.fail_vec         <= '0;
               bus.first_fail       <= '0;
               bus.first_fail_valid <= 1'b0;
            end
            SETTLE: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= SAMPLE;
            end
            SAMPLE: begin
               bus.err_count     <= err_next;
               bus.fail_vec[idx] <= |mismatch;
               if (|mismatch && !bus.first_fail_valid) begin
                  bus.first_fail       <= {bus.A, bus.B, bus.out_NOT, bus.out_AND, bus.out_OR};
                  bus.first_fail_valid <= 1'b1;
               end
               if (idx != LAST_IDX) begin
                  idx            <= idx + 2'd1;
                  {bus.A, bus.B} <= idx + 2'd1;
                  cnt            <= SETTLE_LOAD;
                  state          <= SETTLE;
               end else begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.pass <= err_next == 4'd0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: scoreboard bench driving golden and faulty gate models.
module tb_gate_sweep_checker;
   import gate_check_pkg::*;
   localparam int S = 2;
   localparam int P = S + 1;
   typedef struct {
      logic [3:0] fv;
      logic [3:0] err;
      logic       pass;
      logic       ffv;
      logic [4:0] ff;
      int         cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   mode = 0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   sweep_start = 0;
   logic prev_done = 1'b0;
   logic prev_busy = 1'b0;
   logic [2:0] gold;
   exp_t q[$];
   gate_sweep_checker_if bus();
   gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   gate_expect u_gold (.a(bus.A), .b(bus.B), .expected(gold));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Fault injection on top of the golden loopback
   always_comb begin
      bus.out_NOT = gold[BIT_NOT];
      bus.out_AND = gold[BIT_AND];
      bus.out_OR  = gold[BIT_OR];
      if (mode == 1) bus.out_NOT = 1'b0;
      if (mode == 2) bus.out_AND = 1'b1;
      if (mode == 3) {bus.out_NOT, bus.out_AND, bus.out_OR} = ~{gold[BIT_NOT], gold[BIT_AND], gold[BIT_OR]};
   end
   task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", n, got, want);
      end
   endtask
   always @(negedge clk) begin
      if (bus.busy && !prev_busy) sweep_start = cyc;
      if (bus.busy) check("ab_step", {30'd0, bus.A, bus.B}, 32'((cyc - sweep_start) / P));
      if (bus.done && !prev_done) begin
         if (q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("fail_vec", bus.fail_vec, e.fv);
            check("err_count", bus.err_count, e.err);
            check("pass", bus.pass, e.pass);
            check("ff_valid", bus.first_fail_valid, e.ffv);
            check("first_fail", bus.first_fail, e.ff);
         end
      end
      prev_done = bus.done;
      prev_busy = bus.busy;
   end
   task automatic do_start(input logic [3:0] fv, input logic [3:0] err, input logic ps,
                           input logic ffv, input logic [4:0] ff);
      exp_t e;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      e.fv = fv; e.err = err; e.pass = ps; e.ffv = ffv; e.ff = ff;
      e.cyc = cyc + 4 * P;
      q.push_back(e);
   endtask
   task automatic drain();
      for (int i = 0; i < 4 * P + 10 && q.size() != 0; i++) @(negedge clk);
      check("drain_timeout", q.size(), 0);
   endtask
   task automatic check_reset_vals();
      check("rst_ab", {bus.A, bus.B}, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_pass", bus.pass, 0);
      check("rst_err", bus.err_count, 0);
      check("rst_fv", bus.fail_vec, 0);
      check("rst_ff", bus.first_fail, 0);
      check("rst_ffv", bus.first_fail_valid, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL global_timeout got=%0d want=0", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset_vals();
      do_start(4'b0000, 4'd0, 1'b1, 1'b0, 5'b00000);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check("done_hold", bus.done, 1);
      check("done_ab", {bus.A, bus.B}, 2'b11);
      mode = 1;
      do_start(4'b0011, 4'd2, 1'b0, 1'b1, 5'b00000);
      check("restart_done_low", bus.done, 0);
      check("restart_ab", {bus.A, bus.B}, 0);
      drain();
      mode = 2;
      do_start(4'b0111, 4'd3, 1'b0, 1'b1, 5'b00110);
      drain();
      mode = 3;
      do_start(4'b1111, 4'd12, 1'b0, 1'b1, 5'b00011);
      drain();
      mode = 0;
      do_start(4'b0000, 4'd0, 1'b1, 1'b0, 5'b00000);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      check_reset_vals();
      q.delete();
      repeat (15) @(negedge clk);
      check("idle_after_rst", bus.done, 0);
      do_start(4'b0000, 4'd0, 1'b1, 1'b0, 5'b00000);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
